z380_dram_refresh_mc: RTL and testbench
=======================================

// Module: z380_dram_refresh_mc
// PURPOSE
//  Multi-channel DRAM refresh scheduler for the Z380 platform uncore. Per channel: programmable
//  period counter generates refresh ticks, accumulated as a saturating debt; a req/ack handshake
//  hands refreshes to the DRAM controller, so it can postpone up to DEBT_MAX refreshes.
//  Configured and observed through the standard CSR slave port.
// PARAMETERS
//  CSR_BASE  32'h00a23000  byte base of CSR window
//  NUM_CH    2             refresh channels, 1..4
//  PERIOD_W  16            period counter width, 1..16
//  DEBT_W    3             debt counter width; DEBT_MAX = 2**DEBT_W-1 (1..8)
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        reset, synchronous, active-low
//  ref_req       out  NUM_CH   per-channel refresh request (= debt!=0)
//  ref_ack       in   NUM_CH   controller completed one refresh on channel
//  ref_overflow  out  NUM_CH   sticky: tick lost because debt saturated
//  csr           slave csr_if  CSR request/response port
// BEHAVIOUR
//  Reset: one clock; reset synchronous, active-low on rst_n; all state clears at first clk edge
//   with rst_n=0: enables, periods, counters, debt, overflow, ref_req, ref_overflow = 0; CSR rsp_valid=0
//   (in-flight response dropped). Mid-operation reset discards pending debt.
//  CSR map (addr relative to CSR_BASE; ch = 0..NUM_CH-1):
//   +0x00 CTRL   RW [NUM_CH-1:0] channel enable
//   +0x10+0x10*ch PERIOD RW [PERIOD_W-1:0]; upper bits read 0, ignored on write
//   +0x14+0x10*ch STATUS RO-ish [DEBT_W-1:0] debt, [8] overflow, [31:16] count (zero-ext);
//                 write with wdata[8]=1 clears overflow (W1C); other bits ignored
//   any other addr, or channel index >= NUM_CH -> rsp_fault=1, no state change
//  CSR handshake: req_ready = !rsp_valid; on req fire, response registered next cycle;
//   rsp_valid held until rsp_ready; rsp_side_effect = req_write; rdata=0 on writes/faults.
//   CSR writes take effect at the fire edge; wstrb ignored (full-word writes).
//  Period counter (per channel): disabled -> count<=PERIOD, debt<=0 (overflow retained).
//   Enabled: count==0 -> tick, count<=PERIOD; else count<=count-1. Tick spacing = PERIOD+1
//   cycles; PERIOD=0 -> tick every cycle. PERIOD write while enabled applies at next reload.
//   First tick occurs PERIOD+1 cycles after enable edge.
//  Debt update per channel per cycle (ack counts only when debt!=0, stray ack ignored):
//   tick & ~ack -> debt+1, or if debt==DEBT_MAX stays DEBT_MAX and overflow<=1
//   ~tick & ack -> debt-1;  tick & ack -> unchanged (no overflow);  neither -> unchanged
//  ref_req and ref_overflow are direct register outputs (no combinational path from ref_ack).
//   ref_req deasserts the cycle after the ack that brings debt to 0.
//  Simultaneous CSR W1C and overflow set same cycle: set wins.
//  Disable with pending debt: debt cleared, ref_req drops next cycle; later ack ignored.
//  Channels fully independent; no arbitration between channels.
// TESTING
//  1 PERIOD0=3, CTRL=1, ack tied 0 -> ch0 debt 1,2,3.. every 4 cycles; ch1 req stays 0
//  2 DEBT_W=3, PERIOD0=0, no ack -> debt saturates at 7 after 7 ticks, ref_overflow[0]=1 on 8th;
//    STATUS write 0x100 -> overflow reads 0
//  3 debt=1, ack on same cycle as tick -> debt stays 1, ref_req stays 1; ack alone -> req 0 next cycle
//  4 CSR read of 0x28 (NUM_CH=2), write to 0x04 -> rsp_fault=1; rsp_ready held 0 3 cycles ->
//    rsp_valid stays 1, req_ready 0
//  5 enable ch0 with debt=5, rst_n low 1 cycle -> all outputs 0, CTRL/PERIOD read 0
//  6 clear CTRL with debt=2 -> ref_req 0 next cycle, STATUS debt=0, count=PERIOD

Source files
------------

// File: rtl/z380_dram_refresh_mc.sv
// Z380 uncore DRAM refresh scheduler: per-channel period tick generator,
// saturating refresh debt with req/ack hand-off, CSR-programmed.
module z380_dram_refresh_mc #(
  parameter logic [31:0] CSR_BASE = 32'h00a2_3000,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned DEBT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [NUM_CH-1:0] ref_req,
  input  logic [NUM_CH-1:0] ref_ack,
  output logic [NUM_CH-1:0] ref_overflow,
  input  logic              csr_req_valid,
  output logic              csr_req_ready,
  input  logic [31:0]       csr_req_addr,
  input  logic              csr_req_write,
  input  logic [31:0]       csr_req_wdata,
  input  logic [3:0]        csr_req_wstrb,
  output logic              csr_rsp_valid,
  input  logic              csr_rsp_ready,
  output logic [31:0]       csr_rsp_rdata,
  output logic              csr_rsp_fault,
  output logic              csr_rsp_side_effect
);

  localparam logic [DEBT_W-1:0] DEBT_MAX = '1;

  typedef enum logic {S_IDLE = 1'b0, S_RSP = 1'b1} rsp_state_e;

  rsp_state_e          state_q, state_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                fault_q, fault_d;
  logic                side_q, side_d;

  logic [NUM_CH-1:0]   en_q, en_d;
  logic [PERIOD_W-1:0] period_q [NUM_CH];
  logic [PERIOD_W-1:0] period_d [NUM_CH];
  logic [PERIOD_W-1:0] count_q  [NUM_CH];
  logic [PERIOD_W-1:0] count_d  [NUM_CH];
  logic [DEBT_W-1:0]   debt_q   [NUM_CH];
  logic [DEBT_W-1:0]   debt_d   [NUM_CH];
  logic [NUM_CH-1:0]   ovf_q, ovf_d;
  logic [NUM_CH-1:0]   req_q, req_d;

  logic [31:0]         offset;
  logic                hit_ctrl;
  logic [NUM_CH-1:0]   hit_period, hit_status;
  logic                hit_any;
  logic [31:0]         rd_val;
  logic                req_fire;
  logic                wr_fire;
  logic [NUM_CH-1:0]   tick, ack_ok, ovf_set;

  // Write strobes are not honoured and most wdata bits have no home.
  logic unused_csr;
  assign unused_csr = ^{csr_req_wstrb, csr_req_wdata};

  assign csr_req_ready       = (state_q == S_IDLE);
  assign csr_rsp_valid       = (state_q == S_RSP);
  assign csr_rsp_rdata       = rdata_q;
  assign csr_rsp_fault       = fault_q;
  assign csr_rsp_side_effect = side_q;
  assign ref_req             = req_q;
  assign ref_overflow        = ovf_q;

  assign req_fire = csr_req_valid & csr_req_ready;
  assign wr_fire  = req_fire & csr_req_write;

  // Address decode and read-data mux.
  always_comb begin
    offset     = csr_req_addr - CSR_BASE;
    hit_ctrl   = (offset == 32'h0);
    hit_period = '0;
    hit_status = '0;
    rd_val     = '0;
    if (hit_ctrl) rd_val = 32'(en_q);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      hit_period[ch] = (offset == 32'(16 + 16 * ch));
      hit_status[ch] = (offset == 32'(20 + 16 * ch));
      if (hit_period[ch]) rd_val = 32'(period_q[ch]);
      if (hit_status[ch]) begin
        rd_val[DEBT_W-1:0] = debt_q[ch];
        rd_val[8]          = ovf_q[ch];
        rd_val[31:16]      = 16'(count_q[ch]);
      end
    end
    hit_any = hit_ctrl | (|hit_period) | (|hit_status);
  end

  // CSR response FSM: one outstanding response, captured at request fire.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    side_d  = side_q;
    case (state_q)
      S_IDLE: begin
        if (csr_req_valid) begin
          state_d = S_RSP;
          fault_d = !hit_any;
          side_d  = csr_req_write;
          rdata_d = (csr_req_write || !hit_any) ? 32'h0 : rd_val;
        end
      end
      S_RSP: begin
        if (csr_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-channel period counter, debt accounting and CSR side effects.
  always_comb begin
    en_d    = (wr_fire && hit_ctrl) ? csr_req_wdata[NUM_CH-1:0] : en_q;
    ovf_d   = ovf_q;
    req_d   = '0;
    tick    = '0;
    ack_ok  = '0;
    ovf_set = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      period_d[ch] = (wr_fire && hit_period[ch]) ? csr_req_wdata[PERIOD_W-1:0] : period_q[ch];
      count_d[ch]  = count_q[ch];
      debt_d[ch]   = debt_q[ch];
      tick[ch]     = en_q[ch] && (count_q[ch] == '0);
      ack_ok[ch]   = ref_ack[ch] && (debt_q[ch] != '0);
      if (!en_q[ch]) begin
        count_d[ch] = period_q[ch];
        debt_d[ch]  = '0;
      end else begin
        count_d[ch] = tick[ch] ? period_q[ch] : count_q[ch] - PERIOD_W'(1);
        if (tick[ch] && !ack_ok[ch]) begin
          if (debt_q[ch] == DEBT_MAX) ovf_set[ch] = 1'b1;
          else                        debt_d[ch]  = debt_q[ch] + DEBT_W'(1);
        end else if (!tick[ch] && ack_ok[ch]) begin
          debt_d[ch] = debt_q[ch] - DEBT_W'(1);
        end
      end
      if (wr_fire && hit_status[ch] && csr_req_wdata[8]) ovf_d[ch] = 1'b0;
      if (ovf_set[ch]) ovf_d[ch] = 1'b1;
      req_d[ch] = (debt_d[ch] != '0);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      fault_q <= 1'b0;
      side_q  <= 1'b0;
      en_q    <= '0;
      ovf_q   <= '0;
      req_q   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        period_q[ch] <= '0;
        count_q[ch]  <= '0;
        debt_q[ch]   <= '0;
      end
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      side_q  <= side_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      req_q   <= req_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        period_q[ch] <= period_d[ch];
        count_q[ch]  <= count_d[ch];
        debt_q[ch]   <= debt_d[ch];
      end
    end
  end

endmodule

// File: tb/tb_z380_dram_refresh_mc.sv
// Bench for z380_dram_refresh_mc: directed scenarios plus randomized CSR
// traffic and acks, checked every cycle against an integer reference model.
module tb_z380_dram_refresh_mc;

  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned DEBT_W   = 3;
  localparam logic [31:0] CSR_BASE = 32'h00a2_3000;
  localparam int          DEBT_MAX = (1 << DEBT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] ref_req;
  logic [NUM_CH-1:0] ref_ack;
  logic [NUM_CH-1:0] ref_overflow;
  logic              csr_req_valid;
  logic              csr_req_ready;
  logic [31:0]       csr_req_addr;
  logic              csr_req_write;
  logic [31:0]       csr_req_wdata;
  logic [3:0]        csr_req_wstrb;
  logic              csr_rsp_valid;
  logic              csr_rsp_ready;
  logic [31:0]       csr_rsp_rdata;
  logic              csr_rsp_fault;
  logic              csr_rsp_side_effect;

  z380_dram_refresh_mc #(
    .CSR_BASE (CSR_BASE),
    .NUM_CH   (NUM_CH),
    .PERIOD_W (PERIOD_W),
    .DEBT_W   (DEBT_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ref_req             (ref_req),
    .ref_ack             (ref_ack),
    .ref_overflow        (ref_overflow),
    .csr_req_valid       (csr_req_valid),
    .csr_req_ready       (csr_req_ready),
    .csr_req_addr        (csr_req_addr),
    .csr_req_write       (csr_req_write),
    .csr_req_wdata       (csr_req_wdata),
    .csr_req_wstrb       (csr_req_wstrb),
    .csr_rsp_valid       (csr_rsp_valid),
    .csr_rsp_ready       (csr_rsp_ready),
    .csr_rsp_rdata       (csr_rsp_rdata),
    .csr_rsp_fault       (csr_rsp_fault),
    .csr_rsp_side_effect (csr_rsp_side_effect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          write;
    logic [31:0] off;
    logic [31:0] wdata;
  } csr_op_t;

  csr_op_t ops[$];

  // Reference model state: plain integers.
  bit          m_en     [NUM_CH];
  int          m_period [NUM_CH];
  int          m_rem    [NUM_CH];
  int          m_debt   [NUM_CH];
  bit          m_ovf    [NUM_CH];
  bit          m_rsp_valid;
  bit          m_rsp_fault;
  bit          m_rsp_side;
  logic [31:0] m_rsp_rdata;
  bit          last_fire;

  int ack_pct;
  int rdy_pct;
  int n_vec;
  int n_err;
  int cyc;

  logic [31:0] offs [14] = '{32'h00, 32'h10, 32'h14, 32'h20, 32'h24, 32'h10, 32'h14,
                             32'h04, 32'h08, 32'h18, 32'h28, 32'h2c, 32'h30, 32'hffff_fffc};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_req();
    logic [31:0] r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c] = (m_debt[c] > 0);
    return r;
  endfunction

  function automatic logic [31:0] exp_ovf();
    logic [31:0] r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_ovf[c];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 0; m_period[c] = 0; m_rem[c] = 0; m_debt[c] = 0; m_ovf[c] = 0;
    end
    m_rsp_valid = 0;
  endtask

  // Advance the model by one clock edge given the inputs now being driven.
  task automatic model_step();
    bit          fire;
    int          kind;  // 0 fault, 1 ctrl, 2 period, 3 status
    int          ch;
    logic [31:0] o;
    logic [31:0] rd;
    bit          seto [NUM_CH];
    fire = csr_req_valid && !m_rsp_valid;
    kind = 0; ch = 0; rd = '0;
    if (fire) begin
      o = csr_req_addr - CSR_BASE;
      if (o == 0) kind = 1;
      else if (o >= 16 && o < 32'(16 + 16 * NUM_CH)) begin
        ch = int'((o - 16) / 16);
        if (o % 16 == 0)      kind = 2;
        else if (o % 16 == 4) kind = 3;
      end
      case (kind)
        1: for (int c = 0; c < NUM_CH; c++) rd[c] = m_en[c];
        2: rd = 32'(m_period[ch]);
        3: rd = 32'(m_debt[ch]) | (32'(m_ovf[ch]) << 8) | (32'(m_rem[ch]) << 16);
        default: rd = '0;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      bit tk;
      bit ak;
      seto[c] = 0;
      if (!m_en[c]) begin
        m_rem[c]  = m_period[c];
        m_debt[c] = 0;
      end else begin
        tk = (m_rem[c] == 0);
        ak = ref_ack[c] && (m_debt[c] > 0);
        m_rem[c] = tk ? m_period[c] : m_rem[c] - 1;
        if (tk && !ak) begin
          if (m_debt[c] == DEBT_MAX) begin m_ovf[c] = 1; seto[c] = 1; end
          else m_debt[c]++;
        end else if (!tk && ak) begin
          m_debt[c]--;
        end
      end
    end
    if (fire) begin
      if (csr_req_write) begin
        case (kind)
          1: for (int c = 0; c < NUM_CH; c++) m_en[c] = csr_req_wdata[c];
          2: m_period[ch] = int'(csr_req_wdata % (32'd1 << PERIOD_W));
          3: if (csr_req_wdata[8] && !seto[ch]) m_ovf[ch] = 0;
          default: ;
        endcase
      end
      m_rsp_valid = 1;
      m_rsp_fault = (kind == 0);
      m_rsp_side  = csr_req_write;
      m_rsp_rdata = (csr_req_write || kind == 0) ? 32'h0 : rd;
    end else if (m_rsp_valid && csr_rsp_ready) begin
      m_rsp_valid = 0;
    end
    last_fire = fire;
  endtask

  // One clock: compare outputs, drive next inputs, step the model.
  task automatic cycle();
    csr_op_t op;
    cyc++;
    check("ref_req", 32'(ref_req), exp_req());
    check("ref_overflow", 32'(ref_overflow), exp_ovf());
    check("req_ready", 32'(csr_req_ready), 32'(!m_rsp_valid));
    check("rsp_valid", 32'(csr_rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid) begin
      check("rsp_rdata", csr_rsp_rdata, m_rsp_rdata);
      check("rsp_fault", 32'(csr_rsp_fault), 32'(m_rsp_fault));
      check("rsp_side_effect", 32'(csr_rsp_side_effect), 32'(m_rsp_side));
    end
    if (rst_n) begin
      if (csr_req_valid && last_fire) csr_req_valid = 1'b0;
      if (!csr_req_valid && ops.size() != 0) begin
        op = ops.pop_front();
        csr_req_valid = 1'b1;
        csr_req_addr  = CSR_BASE + op.off;
        csr_req_write = op.write;
        csr_req_wdata = op.wdata;
        csr_req_wstrb = 4'($urandom_range(15));
      end
      for (int c = 0; c < NUM_CH; c++) ref_ack[c] = ($urandom_range(99) < ack_pct);
      csr_rsp_ready = ($urandom_range(99) < rdy_pct);
      model_step();
    end else begin
      csr_req_valid = 1'b0;
      ref_ack       = '0;
      model_reset();
      last_fire = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic push_wr(input logic [31:0] off, input logic [31:0] d);
    csr_op_t op;
    op.write = 1; op.off = off; op.wdata = d;
    ops.push_back(op);
  endtask

  task automatic push_rd(input logic [31:0] off);
    csr_op_t op;
    op.write = 0; op.off = off; op.wdata = $urandom();
    ops.push_back(op);
  endtask

  task automatic drain();
    int guard = 0;
    rdy_pct = 100;
    while ((ops.size() != 0 || (csr_req_valid && !last_fire) || m_rsp_valid) && guard < 500) begin
      cycle();
      guard++;
    end
    if (guard >= 500) check("drain_timeout", 32'(guard), 32'(0));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int n, input int ackp, input int rdyp, input int opp);
    logic [31:0] off;
    logic [31:0] d;
    ack_pct = ackp;
    for (int i = 0; i < n; i++) begin
      rdy_pct = rdyp;
      if (ops.size() == 0 && $urandom_range(99) < opp) begin
        off = offs[$urandom_range(13)];
        d   = $urandom();
        if (off == 32'h10 || off == 32'h20) d = (d & 32'hffff_0000) | 32'($urandom_range(9));
        if ($urandom_range(1) == 1) push_wr(off, d);
        else                        push_rd(off);
      end
      if ($urandom_range(999) == 0) pulse_reset();
      else                          cycle();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    ack_pct = 0; rdy_pct = 100; last_fire = 0;
    rst_n = 1'b0;
    csr_req_valid = 1'b0; csr_req_addr = '0; csr_req_write = 1'b0;
    csr_req_wdata = '0; csr_req_wstrb = '0; csr_rsp_ready = 1'b0; ref_ack = '0;
    model_reset();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Period 3 on ch0, no acks: debt steps every 4 cycles, ch1 idle.
    push_wr(32'h10, 32'd3);
    push_wr(32'h00, 32'd1);
    drain();
    run(20);
    push_rd(32'h14);
    push_rd(32'h24);
    drain();

    // Period 0: saturate, overflow, then stop ticking and clear it.
    push_wr(32'h10, 32'h0);
    drain();
    run(12);
    push_rd(32'h14);
    push_wr(32'h00, 32'h0);
    push_wr(32'h14, 32'h100);
    push_rd(32'h14);
    drain();

    // Tick coinciding with ack, then acks alone draining the debt.
    push_wr(32'h00, 32'h1);
    drain();
    ack_pct = 100;
    run(10);
    ack_pct = 0;
    run(3);
    push_wr(32'h10, 32'd50);
    drain();
    ack_pct = 100;
    run(8);
    ack_pct = 0;

    // Faulting addresses and a stalled response.
    push_rd(32'h28);
    push_wr(32'h04, 32'hffff_ffff);
    push_rd(32'hffff_fffc);
    rdy_pct = 0;
    run(6);
    drain();

    // Reset with pending debt.
    push_wr(32'h10, 32'h0);
    push_wr(32'h00, 32'h3);
    drain();
    run(5);
    pulse_reset();
    push_rd(32'h00);
    push_rd(32'h10);
    push_rd(32'h14);
    drain();

    // Disable with pending debt; later acks ignored.
    push_wr(32'h10, 32'd2);
    push_wr(32'h00, 32'h1);
    drain();
    run(7);
    push_wr(32'h00, 32'h0);
    push_rd(32'h14);
    drain();
    ack_pct = 100;
    run(4);
    ack_pct = 0;

    // Randomized traffic with varied ack and response-ready pressure.
    run_random(3000, 20, 70, 30);
    run_random(3000, 5, 40, 50);
    run_random(3000, 60, 90, 20);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
